// File: rtl/ram_cycle_ctrl_if.sv
// CPU-side bus between the 68000 strobes/address decode and the SRAM cycle controller.
// The master is the CPU/decoder side, the slave is ram_cycle_ctrl.
interface ram_cycle_ctrl_if;
    logic _AS;
    logic _UDS;
    logic _LDS;
    logic RW;
    logic ramce;
    logic rom_sel;
    logic maprom_on;
    logic _RAMCE;
    logic _RAMOE;
    logic _WEU;
    logic _WEL;
    logic DTACK;

    modport master (
        output _AS, _UDS, _LDS, RW, ramce, rom_sel, maprom_on,
        input  _RAMCE, _RAMOE, _WEU, _WEL, DTACK
    );

    modport slave (
        input  _AS, _UDS, _LDS, RW, ramce, rom_sel, maprom_on,
        output _RAMCE, _RAMOE, _WEU, _WEL, DTACK
    );
endinterface

// File: rtl/ram_cycle_ctrl.sv
// 68000 SRAM cycle controller: chip/output/write enables plus DTACK after WAIT_STATES extra clocks.
// Define MAPROM_WP_EN to write-protect the F80000-FFFFFF range while maprom is active.
module ram_cycle_ctrl #(
    parameter int WAIT_STATES = 0
) (
    input  logic            CLK,
    input  logic            _RST,
    ram_cycle_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        ACK
    } state_t;

    localparam logic [1:0] WAIT_INIT = WAIT_STATES[1:0];

    state_t     state, state_nxt;
    logic [1:0] wait_cnt, wait_cnt_nxt;
    logic       rw_q, rw_nxt;
    logic       accept;
    logic       cycle_active;
    logic       blocked;

    assign accept = (state == IDLE) && !bus._AS && bus.ramce;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
            rw_q     <= 1'b1;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            rw_q     <= rw_nxt;
        end
    end

    // Once a cycle has started only _AS can end it; ramce is looked at in IDLE alone.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        rw_nxt       = rw_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt    = ACCESS;
                    wait_cnt_nxt = WAIT_INIT;
                    rw_nxt       = bus.RW;
                end
            end
            ACCESS: begin
                if (bus._AS)
                    state_nxt = IDLE;
                else if (wait_cnt == 2'd0)
                    state_nxt = ACK;
                else
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (bus._AS) begin
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 2'd1;
                    if (wait_cnt == 2'd1)
                        state_nxt = ACK;
                end
            end
            ACK: begin
                if (bus._AS)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MAPROM_WP_EN
    logic wp_q;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST)
            wp_q <= 1'b0;
        else if (accept)
            wp_q <= bus.rom_sel & bus.maprom_on & ~bus.RW;
    end

    assign blocked = wp_q;
`else
    wire unused_rom_flags = &{1'b0, bus.rom_sel, bus.maprom_on};

    assign blocked = 1'b0;
`endif

    // Write enables gate the live data strobes so they track the late 68000 write timing.
    assign cycle_active = (state != IDLE);
    assign bus._RAMCE   = ~cycle_active;
    assign bus._RAMOE   = ~(cycle_active & rw_q);
    assign bus._WEU     = ~(cycle_active & ~rw_q & ~bus._UDS & ~blocked);
    assign bus._WEL     = ~(cycle_active & ~rw_q & ~bus._LDS & ~blocked);
    assign bus.DTACK    = (state == ACK);

endmodule

// File: tb/tb_ram_cycle_ctrl.sv
// Directed bench for ram_cycle_ctrl: three instances (0, 2, 3 wait states) share one CPU stimulus.
// Outputs are compared as {_RAMCE, _RAMOE, _WEU, _WEL, DTACK}.
module tb_ram_cycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic as_n, uds_n, lds_n, rw, ramce, rom_sel, maprom_on;

    always #5 clk = ~clk;

    ram_cycle_ctrl_if bus [3] ();
    logic [4:0] obs [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_bus
            assign bus[g]._AS       = as_n;
            assign bus[g]._UDS      = uds_n;
            assign bus[g]._LDS      = lds_n;
            assign bus[g].RW        = rw;
            assign bus[g].ramce     = ramce;
            assign bus[g].rom_sel   = rom_sel;
            assign bus[g].maprom_on = maprom_on;
            assign obs[g] = {bus[g]._RAMCE, bus[g]._RAMOE, bus[g]._WEU, bus[g]._WEL, bus[g].DTACK};
        end
    endgenerate

    ram_cycle_ctrl #(.WAIT_STATES(0)) dut_ws0 (.CLK(clk), ._RST(rst_n), .bus(bus[0]));
    ram_cycle_ctrl #(.WAIT_STATES(2)) dut_ws2 (.CLK(clk), ._RST(rst_n), .bus(bus[1]));
    ram_cycle_ctrl #(.WAIT_STATES(3)) dut_ws3 (.CLK(clk), ._RST(rst_n), .bus(bus[2]));

    // Stimulus bits: {_AS, _UDS, _LDS, RW, ramce, rom_sel, maprom_on}
    localparam logic [6:0] S_IDLE      = 7'b1111000;
    localparam logic [6:0] S_RD        = 7'b0001100;
    localparam logic [6:0] S_RD_NOCE   = 7'b0001000;
    localparam logic [6:0] S_RD_NOSTB  = 7'b0111100;
    localparam logic [6:0] S_WR_ADDR   = 7'b0110100;
    localparam logic [6:0] S_WR_WORD   = 7'b0000100;
    localparam logic [6:0] S_WR_RWHI   = 7'b0001100;
    localparam logic [6:0] S_WR_BYTE   = 7'b0100100;
    localparam logic [6:0] S_ROM_WR    = 7'b0000111;
    localparam logic [6:0] S_ROM_NOMAP = 7'b0000110;

    localparam logic [4:0] E_IDLE      = 5'b11110;
    localparam logic [4:0] E_RD        = 5'b00110;
    localparam logic [4:0] E_RD_ACK    = 5'b00111;
    localparam logic [4:0] E_WR_NOSTB  = 5'b01110;
    localparam logic [4:0] E_WR_NOACK  = 5'b01111;
    localparam logic [4:0] E_WR_WORD   = 5'b01000;
    localparam logic [4:0] E_WR_ACK    = 5'b01001;
    localparam logic [4:0] E_BYTE      = 5'b01100;
    localparam logic [4:0] E_BYTE_ACK  = 5'b01101;

`ifdef MAPROM_WP_EN
    localparam logic [4:0] E_ROM_WR     = E_WR_NOSTB;
    localparam logic [4:0] E_ROM_WR_ACK = E_WR_NOACK;
`else
    localparam logic [4:0] E_ROM_WR     = E_WR_WORD;
    localparam logic [4:0] E_ROM_WR_ACK = E_WR_ACK;
`endif

    typedef struct {
        int         dut;
        logic [6:0] stim;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add_vec(input int dut, input logic [6:0] stim, input logic [4:0] exp,
                           input string name);
        vec_t v;
        v.dut  = dut;
        v.stim = stim;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic [6:0] stim);
        {as_n, uds_n, lds_n, rw, ramce, rom_sel, maprom_on} = stim;
    endtask

    task automatic check_output(input string name, input int dut, input logic [4:0] exp);
        checks++;
        if (obs[dut] !== exp) begin
            failures++;
            $display("[TB] FAIL %s (dut %0d): got %b expected %b", name, dut, obs[dut], exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Each entry: inputs driven at the falling edge, outputs checked at the next falling edge.
        add_vec(0, S_RD,        E_RD,         "rd_ws0_access");
        add_vec(0, S_RD,        E_RD_ACK,     "rd_ws0_ack");
        add_vec(0, S_RD_NOCE,   E_RD_ACK,     "rd_ws0_ramce_drop_held");
        add_vec(0, S_IDLE,      E_IDLE,       "rd_ws0_release");
        add_vec(0, S_RD_NOCE,   E_IDLE,       "unselected_as_ignored");
        add_vec(0, S_IDLE,      E_IDLE,       "idle_gap");

        add_vec(2, S_WR_ADDR,   E_WR_NOSTB,   "wr_ws3_access");
        add_vec(2, S_WR_WORD,   E_WR_WORD,    "wr_ws3_wait_a");
        add_vec(2, S_WR_RWHI,   E_WR_WORD,    "wr_ws3_rw_registered");
        add_vec(2, S_WR_WORD,   E_WR_WORD,    "wr_ws3_wait_c");
        add_vec(2, S_WR_WORD,   E_WR_ACK,     "wr_ws3_ack_edge5");
        add_vec(2, S_WR_ADDR,   E_WR_NOACK,   "wr_ws3_strobes_up");
        add_vec(2, S_IDLE,      E_IDLE,       "wr_ws3_release");

        add_vec(0, S_WR_BYTE,   E_BYTE,       "byte_access");
        add_vec(0, S_WR_BYTE,   E_BYTE_ACK,   "byte_ack");
        add_vec(0, S_IDLE,      E_IDLE,       "byte_release");

        add_vec(1, S_RD_NOSTB,  E_RD,         "abort_ws2_access");
        add_vec(1, S_RD_NOSTB,  E_RD,         "abort_ws2_wait");
        add_vec(1, S_IDLE,      E_IDLE,       "abort_ws2_idle");
        add_vec(1, S_IDLE,      E_IDLE,       "abort_ws2_no_dtack");

        add_vec(0, S_RD,        E_RD,         "b2b_first_access");
        add_vec(0, S_RD,        E_RD_ACK,     "b2b_first_ack");
        add_vec(0, S_IDLE,      E_IDLE,       "b2b_gap");
        add_vec(0, S_RD,        E_RD,         "b2b_second_access");
        add_vec(0, S_RD,        E_RD_ACK,     "b2b_second_ack");
        add_vec(0, S_IDLE,      E_IDLE,       "b2b_release");

        add_vec(0, S_ROM_WR,    E_ROM_WR,     "rom_wr_access");
        add_vec(0, S_ROM_WR,    E_ROM_WR_ACK, "rom_wr_ack");
        add_vec(0, S_IDLE,      E_IDLE,       "rom_wr_release");
        add_vec(0, S_ROM_NOMAP, E_WR_WORD,    "rom_nomap_access");
        add_vec(0, S_ROM_NOMAP, E_WR_ACK,     "rom_nomap_ack");
        add_vec(0, S_IDLE,      E_IDLE,       "rom_nomap_release");

        // Reset held with a selected _AS low: everything idle, before and after clock edges.
        rst_n = 1'b0;
        apply_stimulus(S_RD);
        #1;
        for (int d = 0; d < 3; d++) check_output("reset_no_clock", d, E_IDLE);
        @(negedge clk);
        step();
        step();
        for (int d = 0; d < 3; d++) check_output("reset_held", d, E_IDLE);
        apply_stimulus(S_IDLE);
        rst_n = 1'b1;
        step();
        check_output("post_reset_idle", 0, E_IDLE);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].stim);
            step();
            check_output(vecs[i].name, vecs[i].dut, vecs[i].exp);
        end

        // Reset pulse in ACK must drop DTACK and all enables without waiting for a clock.
        apply_stimulus(S_RD);
        step();
        step();
        check_output("pre_reset_ack", 0, E_RD_ACK);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_ws0", 0, E_IDLE);
        check_output("async_reset_ws3", 2, E_IDLE);
        @(negedge clk);
        step();
        check_output("reset_in_cycle_held", 0, E_IDLE);
        rst_n = 1'b1;
        step();
        check_output("post_reset_accept", 0, E_RD);
        step();
        check_output("post_reset_ack", 0, E_RD_ACK);
        apply_stimulus(S_IDLE);
        step();
        check_output("post_reset_release", 0, E_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
